// File: rtl/pc_ctrl_pkg.sv
// Shared types and helpers for the fetch-end program counter controller.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    TRAP = 2'd2
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;

  // A target is illegal when it is not word aligned or lies beyond instruction memory.
  function automatic logic is_bad_target(input logic [31:0] br_pc, input int pc_w);
    logic bad;
    bad = (br_pc[1:0] != 2'b00);
    if ((br_pc >> pc_w) != 32'd0) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-end PC owner: sequential fetch, EX redirects, one buffered redirect, trap on bad targets.
// Handshake: imem_ready=1 means memory accepts Cur_PC on this rising edge; a redirect
// (PcSel) is consumed on the edge where it is seen, with flushes asserted in the same cycle.
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int                PC_W     = 9,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             PcSel,
  input  logic [31:0]      BrPC,
  input  logic             trap_clr,
  output logic [PC_W-1:0]  Cur_PC,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             trap,
  output logic [31:0]      trap_pc,
  output logic [CNT_W-1:0] redir_cnt,
  output logic [1:0]       dbg_state_o
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic            trap_q, trap_d;
  logic [31:0]     trap_pc_q, trap_pc_d;
  logic            cnt_inc;
  logic            flush;
  logic            bad;
  logic [PC_W-1:0] target;

  assign bad    = is_bad_target(BrPC, PC_W);
  assign target = BrPC[PC_W-1:0];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    trap_d    = trap_q;
    trap_pc_d = trap_pc_q;
    cnt_inc   = 1'b0;
    flush     = 1'b0;
    unique case (state_q)
      RUN: begin
        flush = PcSel;
        if (PcSel && bad) begin
          state_d   = TRAP;
          trap_d    = 1'b1;
          trap_pc_d = BrPC;
        end else if (PcSel && imem_ready) begin
          pc_d    = target;
          cnt_inc = 1'b1;
        end else if (PcSel) begin
          pend_d  = target;
          state_d = PEND;
        end else if (!stall && imem_ready) begin
          pc_d = pc_q + PC_W'(INSTR_BYTES);
        end
      end
      PEND: begin
        flush = PcSel;
        if (PcSel && bad) begin
          state_d   = TRAP;
          trap_d    = 1'b1;
          trap_pc_d = BrPC;
        end else if (PcSel) begin
          // Younger redirect replaces the buffered one; it still counts only once.
          pend_d = target;
        end else if (imem_ready) begin
          pc_d    = pend_q;
          cnt_inc = 1'b1;
          state_d = RUN;
        end
      end
      TRAP: begin
        if (trap_clr) begin
          pc_d    = RESET_PC;
          trap_d  = 1'b0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      pend_q    <= '0;
      trap_q    <= 1'b0;
      trap_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      trap_q    <= trap_d;
      trap_pc_q <= trap_pc_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_redir_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (cnt_inc),
    .clear (1'b0),
    .cnt   (redir_cnt)
  );

  assign Cur_PC      = pc_q;
  assign flush_if_id = flush;
  assign flush_id_ex = flush;
  assign trap        = trap_q;
  assign trap_pc     = trap_pc_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with hand-computed expected values.
module tb_pc_fetch_ctrl;

  localparam int PC_W  = 9;
  localparam int CNT_W = 3;

  logic             clk;
  logic             reset;
  logic             stall;
  logic             imem_ready;
  logic             PcSel;
  logic [31:0]      BrPC;
  logic             trap_clr;
  logic [PC_W-1:0]  Cur_PC;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             trap;
  logic [31:0]      trap_pc;
  logic [CNT_W-1:0] redir_cnt;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] S_RUN = 2'd0, S_PEND = 2'd1, S_TRAP = 2'd2;

  pc_fetch_ctrl #(.PC_W(PC_W), .RESET_PC('0), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .imem_ready  (imem_ready),
    .PcSel       (PcSel),
    .BrPC        (BrPC),
    .trap_clr    (trap_clr),
    .Cur_PC      (Cur_PC),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .trap        (trap),
    .trap_pc     (trap_pc),
    .redir_cnt   (redir_cnt),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic sel, input logic [31:0] pc, input logic rdy, input logic stl);
    PcSel      = sel;
    BrPC       = pc;
    imem_ready = rdy;
    stall      = stl;
    #1;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; imem_ready = 1'b1; PcSel = 1'b0; BrPC = '0; trap_clr = 1'b0;
    #12;
    check("rst_pc", 32'(Cur_PC), 32'h0);
    check("rst_trap", 32'(trap), 32'h0);
    check("rst_trap_pc", trap_pc, 32'h0);
    check("rst_cnt", 32'(redir_cnt), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(S_RUN));
    check("rst_flush", 32'({flush_if_id, flush_id_ex}), 32'h0);
    reset = 1'b1;

    // sequential fetch
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("seq_pc", 32'(Cur_PC), 32'(4 * i));
      check("seq_flush", 32'({flush_if_id, flush_id_ex}), 32'h0);
    end

    // redirect with memory ready
    drive(1'b1, 32'h40, 1'b1, 1'b0);
    check("redir_flush", 32'({flush_if_id, flush_id_ex}), 32'h3);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("redir_pc", 32'(Cur_PC), 32'h40);
    check("redir_cnt1", 32'(redir_cnt), 32'd1);

    // buffered redirect, overwritten while pending
    drive(1'b1, 32'h80, 1'b0, 1'b0);
    check("pend_flush", 32'(flush_if_id), 32'h1);
    tick();
    check("pend_state", 32'(dbg_state), 32'(S_PEND));
    check("pend_hold1", 32'(Cur_PC), 32'h40);
    drive(1'b1, 32'hC0, 1'b0, 1'b0);
    check("pend_flush2", 32'(flush_id_ex), 32'h1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("pend_noflush", 32'({flush_if_id, flush_id_ex}), 32'h0);
    tick();
    check("pend_hold2", 32'(Cur_PC), 32'h40);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("pend_apply", 32'(Cur_PC), 32'hC0);
    check("pend_cnt", 32'(redir_cnt), 32'd2);
    check("pend_run", 32'(dbg_state), 32'(S_RUN));
    tick();
    check("pend_seq", 32'(Cur_PC), 32'hC4);

    // redirect beats stall
    drive(1'b1, 32'h20, 1'b1, 1'b1);
    check("stall_flush", 32'({flush_if_id, flush_id_ex}), 32'h3);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    check("stall_redir", 32'(Cur_PC), 32'h20);
    check("stall_cnt", 32'(redir_cnt), 32'd3);
    tick();
    check("stall_hold", 32'(Cur_PC), 32'h20);

    // misaligned target traps
    drive(1'b1, 32'h42, 1'b1, 1'b0);
    check("trap_flush", 32'(flush_if_id), 32'h1);
    tick();
    drive(1'b1, 32'h80, 1'b1, 1'b0);
    check("trap_set", 32'(trap), 32'h1);
    check("trap_pc42", trap_pc, 32'h42);
    check("trap_frozen", 32'(Cur_PC), 32'h20);
    check("trap_noflush", 32'({flush_if_id, flush_id_ex}), 32'h0);
    tick();
    check("trap_ignore", 32'(Cur_PC), 32'h20);
    check("trap_cnt", 32'(redir_cnt), 32'd3);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    trap_clr = 1'b1;
    tick();
    trap_clr = 1'b0;
    check("clr_pc", 32'(Cur_PC), 32'h0);
    check("clr_trap", 32'(trap), 32'h0);
    check("clr_trap_pc", trap_pc, 32'h42);

    // out-of-range target traps
    drive(1'b1, 32'h200, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("range_trap", 32'(trap), 32'h1);
    check("range_pc", trap_pc, 32'h200);
    check("range_state", 32'(dbg_state), 32'(S_TRAP));
    trap_clr = 1'b1;
    tick();
    trap_clr = 1'b0;
    check("clr2_pc", 32'(Cur_PC), 32'h0);

    // reset while pending
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("mid_pend", 32'(dbg_state), 32'(S_PEND));
    reset = 1'b0;
    #1;
    check("mid_rst_pc", 32'(Cur_PC), 32'h0);
    check("mid_rst_state", 32'(dbg_state), 32'(S_RUN));
    check("mid_rst_cnt", 32'(redir_cnt), 32'd0);
    imem_ready = 1'b1;
    reset = 1'b1;
    tick();
    check("mid_discard", 32'(Cur_PC), 32'h4);

    // wrap at top of memory
    drive(1'b1, 32'h1FC, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("wrap_top", 32'(Cur_PC), 32'h1FC);
    tick();
    check("wrap_zero", 32'(Cur_PC), 32'h0);

    // counter saturation (1 so far, 7 more redirects)
    for (int i = 1; i <= 7; i++) begin
      drive(1'b1, 32'(i * 16), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("sat_pc", 32'(Cur_PC), 32'h70);
    check("sat_cnt", 32'(redir_cnt), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
